// File: rtl/mil_mem_pkg.sv
// Shared types for the memory writers: FSM state encoding and the per-word watchdog limit.
// The watchdog limit is only referenced when MEM_BURST_WRITER_TIMEOUT_EN is defined.
package mil_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    PRE_WRITE,
    WRITE,
    POST_WRITE,
    RELEASE
  } wr_state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/mem_burst_writer_if.sv
// Client push channel plus arbiter/memory handshake for mem_burst_writer.
// master = environment (clients, arbiter, memory); slave = the writer.
interface mem_burst_writer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              push_valid;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic              arb_request;
  logic              arb_grant;
  logic              mem_busy;

  modport master (
    output push_valid, push_addr, push_data, arb_grant, mem_busy,
    input  push_ready, arb_request
  );

  modport slave (
    input  push_valid, push_addr, push_data, arb_grant, mem_busy,
    output push_ready, arb_request
  );
endinterface

// File: rtl/mem_wr_fifo.sv
// DEPTH x WIDTH synchronous FIFO with occupancy output; head word is visible on rdata without a read strobe.
// Pushes while full and pops while empty are ignored.
module mem_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/mem_burst_writer.sv
// Queues client address/data pairs and writes them to shared memory in arbitrated bursts of up to MAX_BURST words.
// Optional MEM_BURST_WRITER_TIMEOUT_EN adds a per-word watchdog that drops a stuck word and sets sticky timeout_err.
module mem_burst_writer
  import mil_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   nRst,
  mem_burst_writer_if.slave      bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle,
  output logic                   done,
  output wire  [ADDR_W-1:0]      mem_wr_addr,
  output wire  [DATA_W-1:0]      mem_wr_data,
  output wire                    mem_wr_enable
`ifdef MEM_BURST_WRITER_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  wr_state_t                  state;
  logic [CNT_W-1:0]           burst_cnt;
  logic                       req_q;
  logic                       drive_q;
  logic                       we_q;
  logic                       done_q;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;
  logic                       word_done;
  logic [ADDR_W+DATA_W-1:0]   head;

  mem_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .nRst  (nRst),
    .push  (bus.push_valid),
    .wdata ({bus.push_addr, bus.push_data}),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A revoked grant freezes the word in place instead of completing it.
  assign word_done = (state == WRITE) && bus.arb_grant && !bus.mem_busy;

`ifdef MEM_BURST_WRITER_TIMEOUT_EN
  logic [15:0] wdog;
  logic        in_word;
  logic        timeout_hit;

  assign in_word     = (state == PRE_WRITE) || (state == WRITE);
  assign timeout_hit = in_word && (wdog == TIMEOUT_LIMIT);
  assign pop         = word_done || timeout_hit;
`else
  assign pop         = word_done;
`endif

  assign bus.push_ready  = !fifo_full;
  assign bus.arb_request = req_q;
  assign done            = done_q;
  assign idle            = fifo_empty && (state == IDLE);
  assign mem_wr_addr     = drive_q ? head[ADDR_W+DATA_W-1:DATA_W] : {ADDR_W{1'bz}};
  assign mem_wr_data     = drive_q ? head[DATA_W-1:0] : {DATA_W{1'bz}};
  assign mem_wr_enable   = bus.arb_grant ? we_q : 1'bz;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      req_q     <= 1'b0;
      drive_q   <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef MEM_BURST_WRITER_TIMEOUT_EN
      wdog        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MEM_BURST_WRITER_TIMEOUT_EN
      if (timeout_hit) begin
        state       <= RELEASE;
        req_q       <= 1'b0;
        drive_q     <= 1'b0;
        we_q        <= 1'b0;
        timeout_err <= 1'b1;
      end else begin
        wdog <= in_word ? wdog + 16'd1 : '0;
`endif
        case (state)
          IDLE: begin
            if (!fifo_empty) begin
              state <= WAIT_GRANT;
              req_q <= 1'b1;
            end
          end
          WAIT_GRANT: begin
            if (bus.arb_grant) begin
              state     <= PRE_WRITE;
              burst_cnt <= '0;
              drive_q   <= 1'b1;
              we_q      <= 1'b1;
            end
          end
          PRE_WRITE: begin
            if (bus.arb_grant && bus.mem_busy) begin
              state <= WRITE;
              we_q  <= 1'b0;
            end
          end
          WRITE: begin
            if (word_done) begin
              state     <= POST_WRITE;
              drive_q   <= 1'b0;
              done_q    <= 1'b1;
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
          POST_WRITE: begin
            if (!fifo_empty && (burst_cnt < BURST_LIM) && bus.arb_grant) begin
              state   <= PRE_WRITE;
              drive_q <= 1'b1;
              we_q    <= 1'b1;
            end else begin
              state <= RELEASE;
              req_q <= 1'b0;
            end
          end
          RELEASE: state <= IDLE;
          default: begin
            state   <= IDLE;
            req_q   <= 1'b0;
            drive_q <= 1'b0;
            we_q    <= 1'b0;
          end
        endcase
`ifdef MEM_BURST_WRITER_TIMEOUT_EN
      end
`endif
    end
  end
endmodule

// File: tb/tb_mem_burst_writer.sv
// Directed bench for mem_burst_writer: a two-cycle busy memory responder and a write/done monitor feed per-scenario checks.
// Build with MEM_BURST_WRITER_TIMEOUT_EN to include the watchdog scenario.
module tb_mem_burst_writer;
  logic clk  = 1'b0;
  logic nRst = 1'b0;
  wire [3:0]  level;
  wire        idle;
  wire        done;
  wire [15:0] mem_wr_addr;
  wire [15:0] mem_wr_data;
  wire        mem_wr_enable;
`ifdef MEM_BURST_WRITER_TIMEOUT_EN
  wire        timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  bit          resp_on    = 1'b1;
  bit          force_busy = 1'b0;
  int          busy_cnt   = 0;
  bit          prev_en    = 1'b0;
  int          done_cnt   = 0;
  logic [31:0] wr_q [$];

  mem_burst_writer_if #(.ADDR_W(16), .DATA_W(16)) bus();

  mem_burst_writer #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(8), .MAX_BURST(4)
  ) dut (
    .clk           (clk),
    .nRst          (nRst),
    .bus           (bus),
    .level         (level),
    .idle          (idle),
    .done          (done),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_enable (mem_wr_enable)
`ifdef MEM_BURST_WRITER_TIMEOUT_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: a strobe seen at a falling edge holds busy high for two cycles.
  always @(negedge clk) begin
    if (!resp_on) begin
      busy_cnt     = 0;
      bus.mem_busy = force_busy;
    end else if (busy_cnt != 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) bus.mem_busy = 1'b0;
    end else if (mem_wr_enable === 1'b1) begin
      bus.mem_busy = 1'b1;
      busy_cnt     = 2;
    end
  end

  always @(negedge clk) begin
    if (mem_wr_enable === 1'b1 && !prev_en) wr_q.push_back({mem_wr_addr, mem_wr_data});
    prev_en = (mem_wr_enable === 1'b1);
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    bus.arb_grant = 1'b1;
    tick();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
    total++; if (bus.push_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.push_ready); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (bus.arb_request !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.arb_request); end
    total++; if (mem_wr_enable !== 1'b0) begin bad++; $display("FAIL reset_we_granted got=%b want=0", mem_wr_enable); end
    total++; if (mem_wr_addr !== 16'hzzzz && mem_wr_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=z", mem_wr_addr); end
    bus.arb_grant = 1'b0;
    #1;
    total++; if (mem_wr_enable === 1'b1) begin bad++; $display("FAIL reset_we_ungranted got=%b want=z", mem_wr_enable); end
    tick();
    nRst = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    int base_w = wr_q.size();
    int base_d = done_cnt;
    bus.arb_grant  = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_addr  = 16'h0010;
    bus.push_data  = 16'hA5A5;
    tick();
    bus.push_valid = 1'b0;
    total++; if (level !== 4'd1) begin bad++; $display("FAIL single_level got=%0d want=1", level); end
    total++; if (bus.arb_request !== 1'b0) begin bad++; $display("FAIL single_req_idle got=%b want=0", bus.arb_request); end
    tick();
    total++; if (bus.arb_request !== 1'b1) begin bad++; $display("FAIL single_req got=%b want=1", bus.arb_request); end
    total++; if (mem_wr_enable !== 1'b0) begin bad++; $display("FAIL single_we_wait got=%b want=0", mem_wr_enable); end
    tick();
    total++; if (mem_wr_enable !== 1'b1) begin bad++; $display("FAIL single_we_pre got=%b want=1", mem_wr_enable); end
    total++; if (mem_wr_addr !== 16'h0010 || mem_wr_data !== 16'hA5A5) begin
      bad++; $display("FAIL single_bus got=%h/%h want=0010/a5a5", mem_wr_addr, mem_wr_data);
    end
    tick();
    total++; if (mem_wr_enable !== 1'b0 || mem_wr_addr !== 16'h0010) begin
      bad++; $display("FAIL single_write_phase got we=%b addr=%h want we=0 addr=0010", mem_wr_enable, mem_wr_addr);
    end
    tick();
    tick();
    total++; if (done !== 1'b1 || level !== 4'd0) begin
      bad++; $display("FAIL single_done got done=%b level=%0d want 1/0", done, level);
    end
    tick();
    total++; if (done !== 1'b0 || bus.arb_request !== 1'b0 || idle !== 1'b0) begin
      bad++; $display("FAIL single_release got done=%b req=%b idle=%b want 0/0/0", done, bus.arb_request, idle);
    end
    tick();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b want=1", idle); end
    total++; if (wr_q.size() - base_w != 1 || done_cnt - base_d != 1) begin
      bad++; $display("FAIL single_counts got writes=%0d dones=%0d want 1/1", wr_q.size() - base_w, done_cnt - base_d);
    end else if (wr_q[base_w] !== 32'h0010_A5A5) begin
      bad++; $display("FAIL single_word got=%h want=0010a5a5", wr_q[base_w]);
    end
  endtask

  task automatic test_burst_limit();
    int base_w = wr_q.size();
    int base_d = done_cnt;
    int gaps = 0;
    int gap_len = 0;
    int low_run = 0;
    int first_fall_w = -1;
    bit saw_high = 1'b0;
    bit finished = 1'b0;
    bus.arb_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.push_valid = 1'b1;
      bus.push_addr  = 16'h0100 + 16'(i);
      bus.push_data  = 16'hB000 + 16'(i);
      tick();
    end
    bus.push_valid = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      tick();
      if (bus.arb_request === 1'b0) begin
        if (saw_high && low_run == 0 && first_fall_w < 0) first_fall_w = wr_q.size() - base_w;
        low_run++;
      end else begin
        if (saw_high && low_run > 0) begin
          gaps++;
          gap_len = low_run;
        end
        saw_high = 1'b1;
        low_run  = 0;
      end
      if (idle === 1'b1 && wr_q.size() - base_w == 6) finished = 1'b1;
    end
    total++; if (!finished) begin bad++; $display("FAIL burst_timeout got writes=%0d want=6", wr_q.size() - base_w); end
    total++; if (first_fall_w != 4) begin bad++; $display("FAIL burst_first_len got=%0d want=4", first_fall_w); end
    // Between bursts the request stays low through RELEASE and the following IDLE cycle.
    total++; if (gaps != 1 || gap_len != 2) begin
      bad++; $display("FAIL burst_gap got gaps=%0d len=%0d want 1/2", gaps, gap_len);
    end
    total++; if (done_cnt - base_d != 6) begin bad++; $display("FAIL burst_dones got=%0d want=6", done_cnt - base_d); end
    for (int i = 0; i < 6 && finished; i++) begin
      total++; if (wr_q[base_w + i] !== {16'h0100 + 16'(i), 16'hB000 + 16'(i)}) begin
        bad++; $display("FAIL burst_order[%0d] got=%h want=%h", i, wr_q[base_w + i], {16'h0100 + 16'(i), 16'hB000 + 16'(i)});
      end
    end
  endtask

  task automatic test_full_fifo();
    int base_w = wr_q.size();
    bit found = 1'b0;
    bit finished = 1'b0;
    bus.arb_grant = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.push_valid = 1'b1;
      bus.push_addr  = 16'h0200 + 16'(i);
      bus.push_data  = 16'hC000 + 16'(i);
      total++; if (bus.push_ready !== 1'b1) begin bad++; $display("FAIL full_ready[%0d] got=0 want=1", i); end
      tick();
    end
    bus.push_addr = 16'h0208;
    bus.push_data = 16'hC008;
    total++; if (bus.push_ready !== 1'b0 || level !== 4'd8) begin
      bad++; $display("FAIL full_state got ready=%b level=%0d want 0/8", bus.push_ready, level);
    end
    tick(); tick(); tick();
    total++; if (level !== 4'd8) begin bad++; $display("FAIL full_hold_level got=%0d want=8", level); end
    total++; if (bus.arb_request !== 1'b1 || idle !== 1'b0) begin
      bad++; $display("FAIL release_req got req=%b idle=%b want 1/0", bus.arb_request, idle);
    end
    total++; if (mem_wr_enable === 1'b1) begin bad++; $display("FAIL release_we got=%b want=z", mem_wr_enable); end
    total++; if ((mem_wr_addr !== 16'hzzzz && mem_wr_addr !== 16'h0000) || (mem_wr_data !== 16'hzzzz && mem_wr_data !== 16'h0000)) begin
      bad++; $display("FAIL release_bus got=%h/%h want=z/z", mem_wr_addr, mem_wr_data);
    end
    total++; if (wr_q.size() != base_w) begin bad++; $display("FAIL release_nowrite got=%0d want=0", wr_q.size() - base_w); end
    bus.arb_grant = 1'b1;
    for (int c = 0; c < 50 && !found; c++) begin
      tick();
      if (bus.push_ready === 1'b1) found = 1'b1;
    end
    total++; if (!found || level !== 4'd7 || wr_q.size() - base_w != 1) begin
      bad++; $display("FAIL full_first_pop got found=%b level=%0d writes=%0d want 1/7/1", found, level, wr_q.size() - base_w);
    end
    tick();
    bus.push_valid = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      tick();
      if (idle === 1'b1 && wr_q.size() - base_w == 9) finished = 1'b1;
    end
    total++; if (!finished) begin bad++; $display("FAIL full_drain got writes=%0d want=9", wr_q.size() - base_w); end
    for (int i = 0; i < 9 && finished; i++) begin
      total++; if (wr_q[base_w + i] !== {16'h0200 + 16'(i), 16'hC000 + 16'(i)}) begin
        bad++; $display("FAIL full_order[%0d] got=%h want=%h", i, wr_q[base_w + i], {16'h0200 + 16'(i), 16'hC000 + 16'(i)});
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit found = 1'b0;
    bus.arb_grant = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.push_valid = 1'b1;
      bus.push_addr  = 16'h0300 + 16'(i);
      bus.push_data  = 16'hD000 + 16'(i);
      tick();
    end
    bus.push_valid = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (mem_wr_enable === 1'b1) found = 1'b1;
    end
    tick();
    total++; if (!found || mem_wr_enable !== 1'b0 || mem_wr_addr !== 16'h0300) begin
      bad++; $display("FAIL midrst_write got found=%b we=%b addr=%h want 1/0/0300", found, mem_wr_enable, mem_wr_addr);
    end
    #2;
    nRst = 1'b0;
    #1;
    total++; if (level !== 4'd0 || idle !== 1'b1 || bus.push_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_fifo got level=%0d idle=%b ready=%b want 0/1/1", level, idle, bus.push_ready);
    end
    total++; if (bus.arb_request !== 1'b0 || done !== 1'b0 || mem_wr_enable !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl got req=%b done=%b we=%b want 0/0/0", bus.arb_request, done, mem_wr_enable);
    end
    total++; if (mem_wr_addr !== 16'hzzzz && mem_wr_addr !== 16'h0000) begin
      bad++; $display("FAIL midrst_addr got=%h want=z", mem_wr_addr);
    end
    resp_on    = 1'b0;
    force_busy = 1'b0;
    tick();
    nRst = 1'b1;
    tick();
    resp_on = 1'b1;
    total++; if (idle !== 1'b1 || level !== 4'd0) begin
      bad++; $display("FAIL midrst_after got idle=%b level=%0d want 1/0", idle, level);
    end
  endtask

`ifdef MEM_BURST_WRITER_TIMEOUT_EN
  task automatic test_timeout();
    int base_w;
    int base_d;
    bit found = 1'b0;
    bit finished = 1'b0;
    bus.arb_grant = 1'b1;
    resp_on    = 1'b0;
    force_busy = 1'b1;
    base_w = wr_q.size();
    base_d = done_cnt;
    for (int i = 0; i < 2; i++) begin
      bus.push_valid = 1'b1;
      bus.push_addr  = 16'h0400 + 16'(i);
      bus.push_data  = 16'hE000 + 16'(i);
      tick();
    end
    bus.push_valid = 1'b0;
    for (int c = 0; c < 70000 && !found; c++) begin
      tick();
      if (timeout_err === 1'b1) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL timeout_flag got=%b want=1", timeout_err); end
    total++; if (bus.arb_request !== 1'b0 || level !== 4'd1 || done_cnt != base_d) begin
      bad++; $display("FAIL timeout_drop got req=%b level=%0d dones=%0d want 0/1/0", bus.arb_request, level, done_cnt - base_d);
    end
    force_busy = 1'b0;
    resp_on    = 1'b1;
    for (int c = 0; c < 100 && !finished; c++) begin
      tick();
      if (idle === 1'b1 && wr_q.size() - base_w >= 2) finished = 1'b1;
    end
    total++; if (!finished || wr_q[base_w + 1] !== 32'h0401_E001 || done_cnt - base_d != 1 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_next got finished=%b dones=%0d err=%b want 1/1/1", finished, done_cnt - base_d, timeout_err);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=expired want=finished");
    $fatal(1, "bench stalled");
  end

  initial begin
    bus.push_valid = 1'b0;
    bus.push_addr  = '0;
    bus.push_data  = '0;
    bus.arb_grant  = 1'b0;
    test_reset();
    test_single_word();
    test_burst_limit();
    test_full_fifo();
    test_reset_mid_burst();
`ifdef MEM_BURST_WRITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
